booth_radix4_mult: RTL and testbench
====================================

Name: booth_radix4_mult

Overview:
Parametrised sequential radix-4 (modified) Booth multiplier with its own datapath and controller. It generalises the radix-2 8-bit Booth block to any even WIDTH and adds per-operation signed/unsigned mode. It retires two multiplier bits per iteration and uses a start/busy/done handshake. It sits beside the existing arithmetic units and is driven by the same top-level sequencer.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4
ITER, (WIDTH+2)/2, derived localparam, number of Booth iterations; not overridable

Ports:
clk  input  1  clock, all state on rising edge
rst_b  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start
a  input  WIDTH  multiplicand; sampled with start
b  input  WIDTH  multiplier; sampled with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle completion pulse
product  output  2*WIDTH  result register; holds the last result until the next completion

Behaviour:
- Reset: rst_b is asynchronous, active-low; clock is clk. Reset forces state=IDLE, busy=0, done=0, product=0, and clears the internal registers and iteration counter. Reset mid-operation aborts with no done pulse.
- Operand capture (edge 0, IDLE with start=1):
  - M <= a extended to WIDTH+2 bits (sign-extend if signed_mode, else zero-extend).
  - Q <= b extended the same way; q_m1 <= 0; A (WIDTH+4 bits) <= 0; count <= 0.
  - Next state is SCAN.
- States: IDLE, SCAN, SHIFT, OUTPUT.
  - IDLE -> SCAN on start.
  - SCAN -> SHIFT.
  - SHIFT -> SCAN if count != ITER-1, else SHIFT -> OUTPUT.
  - OUTPUT -> IDLE.
- SCAN: recode the triplet {Q[1],Q[0],q_m1} and update A:
  - 000 or 111: A unchanged.
  - 001 or 010: A += M.
  - 011: A += 2M.
  - 100: A -= 2M.
  - 101 or 110: A -= M.
  - M and 2M are sign-extended to WIDTH+4 bits; arithmetic is modulo 2^(WIDTH+4).
- SHIFT: {A,Q,q_m1} <= arithmetic right shift by 2 (A's MSB replicated); count += 1.
- OUTPUT:
  - product <= low 2*WIDTH bits of {A,Q} (Q includes the 2 extension bits).
  - done is registered and is high for exactly the cycle after this edge.
- Timing:
  - busy=1 from edge 0 through edge 2*ITER+1, then 0. busy and done are never both high.
  - Latency: done is high in the cycle following edge 2*ITER+1. For WIDTH=8 that is the cycle after edge 11.
- Handshake:
  - start while busy is ignored; operand and mode changes during busy have no effect.
  - start in the done cycle (state is already IDLE) is accepted, so back-to-back operations lose no cycles.
- Result semantics:
  - signed_mode=1: product is the exact two's-complement product, including (-2^(W-1))^2.
  - signed_mode=0: product is the exact unsigned product.
- Counter width is $clog2(ITER)+1. No overflow is possible: ITER is fixed.

Test Plan:
1. WIDTH=8, signed_mode=1, a=8'h80 (-128), b=8'h80 -> product=16'h4000; done exactly 12 cycles after the start edge (cycle after edge 11); busy high for 11 cycles.
2. WIDTH=8, signed_mode=0, a=8'hFF, b=8'hFF -> product=16'hFE01. Then the same operands with signed_mode=1 -> product=16'h0001. Also signed a=8'hFF, b=8'h01 -> 16'hFFFF.
3. Start pulsed again mid-operation with a=3, b=3 while the first operation is a=7, b=6 unsigned -> single done, product=16'd42. A second start in the done cycle (a=3, b=3) -> next done 12 cycles later, product=16'd9.
4. rst_b pulled low at cycle 5 of an operation -> busy, done and product go to 0 immediately with no done pulse. After release, a fresh 5*5 unsigned -> product=25.
5. WIDTH=16: 1000 random operand pairs in both modes vs a reference model. Every product matches, done latency is 2*9+1 edges, and product holds its value between operations.

Source files
------------

// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: sequential radix-4 Booth multiplier, signed/unsigned per operation,
// start/busy/done handshake, two multiplier bits retired per SCAN/SHIFT pair.
module booth_radix4_mult #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_b,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int ITER = (WIDTH + 2) / 2;
   localparam int CW   = $clog2(ITER) + 1;

   typedef enum logic [1:0] {IDLE, SCAN, SHIFT, OUTPUT} state_t;

   state_t               state_q;
   logic [WIDTH+3:0]     a_q, a_d;
   logic [WIDTH+1:0]     m_q, q_q;
   logic                 qm1_q;
   logic [CW-1:0]        cnt_q;
   logic                 busy_q, done_q;
   logic [2*WIDTH-1:0]   product_q;
   logic [WIDTH+3:0]     m1, m2, addend;
   logic [2:0]           trip;
   logic [2*WIDTH+6:0]   sh;

   always_comb begin
      m1     = {{2{m_q[WIDTH+1]}}, m_q};
      m2     = m1 << 1;
      trip   = {q_q[1:0], qm1_q};
      addend = (trip == 3'b001 || trip == 3'b010) ? m1 :
               (trip == 3'b011)                   ? m2 :
               (trip == 3'b100)                   ? -m2 :
               (trip == 3'b101 || trip == 3'b110) ? -m1 : '0;
      a_d    = a_q + addend;
      sh     = $signed({a_q, q_q, qm1_q}) >>> 2;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= IDLE;
         a_q       <= '0;
         m_q       <= '0;
         q_q       <= '0;
         qm1_q     <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               m_q     <= signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
               q_q     <= signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
               qm1_q   <= 1'b0;
               a_q     <= '0;
               cnt_q   <= '0;
               busy_q  <= 1'b1;
               state_q <= SCAN;
            end
            SCAN: begin
               a_q     <= a_d;
               state_q <= SHIFT;
            end
            SHIFT: begin
               {a_q, q_q, qm1_q} <= sh;
               cnt_q             <= cnt_q + 1'b1;
               state_q           <= (cnt_q == CW'(ITER - 1)) ? OUTPUT : SCAN;
            end
            OUTPUT: begin
               product_q <= {a_q[WIDTH-3:0], q_q};
               done_q    <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_booth_radix4_mult.sv
// tb_booth_radix4_mult: directed and randomised checks of booth_radix4_mult at WIDTH=8 and WIDTH=16.
module tb_booth_radix4_mult;
   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic        start8 = 1'b0, sm8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8;
   logic [15:0] p8;
   logic        start16 = 1'b0, sm16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        busy16, done16;
   logic [31:0] p16;
   int          total = 0, bad = 0;

   always #5 clk = ~clk;

   booth_radix4_mult #(.WIDTH(8)) u8 (
      .clk(clk), .rst_b(rst_b), .start(start8), .signed_mode(sm8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .product(p8)
   );

   booth_radix4_mult #(.WIDTH(16)) u16 (
      .clk(clk), .rst_b(rst_b), .start(start16), .signed_mode(sm16),
      .a(a16), .b(b16), .busy(busy16), .done(done16), .product(p16)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start one WIDTH=8 operation, return cycles to done and busy-cycle count.
   task automatic run8(input logic sm, input logic [7:0] aa, input logic [7:0] bb,
                       output int n, output int bc);
      @(negedge clk);
      sm8 = sm; a8 = aa; b8 = bb; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 1; bc = 0;
      while (!done8 && n < 40) begin
         if (busy8) bc++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic vec8(input string tag, input logic sm, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [15:0] exp);
      int n, bc;
      run8(sm, aa, bb, n, bc);
      chk({tag, "_lat"}, 64'(n), 64'd12);
      chk({tag, "_busy"}, 64'(bc), 64'd11);
      chk({tag, "_busy_in_done"}, 64'(busy8), 64'd0);
      chk({tag, "_prod"}, 64'(p8), 64'(exp));
   endtask

   initial begin
      int n, bc;
      logic [31:0] exp32;
      logic signed [31:0] sa, sb;
      logic [31:0] ua, ub;

      // reset state
      #12;
      chk("rst_busy", 64'(busy8), 64'd0);
      chk("rst_done", 64'(done8), 64'd0);
      chk("rst_prod", 64'(p8), 64'd0);
      @(negedge clk);
      rst_b = 1'b1;

      // signed/unsigned directed vectors
      vec8("s_80x80", 1'b1, 8'h80, 8'h80, 16'h4000);
      vec8("u_FFxFF", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
      vec8("s_FFxFF", 1'b1, 8'hFF, 8'hFF, 16'h0001);
      vec8("s_FFx01", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
      vec8("u_80x80", 1'b0, 8'h80, 8'h80, 16'h4000);
      vec8("s_7Fx80", 1'b1, 8'h7F, 8'h80, 16'hC080);
      vec8("u_00xFF", 1'b0, 8'h00, 8'hFF, 16'h0000);

      // start during busy is ignored; start in the done cycle is accepted
      @(negedge clk);
      sm8 = 1'b0; a8 = 8'd7; b8 = 8'd6; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'd3; b8 = 8'd3; start8 = 1'b1; sm8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 5;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("mid_start_lat", 64'(n), 64'd12);
      chk("mid_start_prod", 64'(p8), 64'd42);
      sm8 = 1'b0; a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("single_done", 64'(done8), 64'd0);
      chk("b2b_busy", 64'(busy8), 64'd1);
      chk("hold_prod", 64'(p8), 64'd42);
      n = 1;
      while (!done8 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_lat", 64'(n), 64'd12);
      chk("b2b_prod", 64'(p8), 64'd9);

      // asynchronous reset mid-operation
      @(negedge clk);
      sm8 = 1'b0; a8 = 8'd9; b8 = 8'd9; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("arst_busy", 64'(busy8), 64'd0);
      chk("arst_done", 64'(done8), 64'd0);
      chk("arst_prod", 64'(p8), 64'd0);
      @(negedge clk);
      rst_b = 1'b1;
      n = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8 || busy8) n++;
      end
      chk("arst_no_done", 64'(n), 64'd0);
      vec8("u_5x5", 1'b0, 8'd5, 8'd5, 16'd25);

      // WIDTH=16: corners then random pairs against an arithmetic reference
      for (int i = 0; i < 1004; i++) begin
         @(negedge clk);
         if (i == 0)      begin sm16 = 1'b1; a16 = 16'h8000; b16 = 16'h8000; end
         else if (i == 1) begin sm16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF; end
         else if (i == 2) begin sm16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h7FFF; end
         else if (i == 3) begin sm16 = 1'b0; a16 = 16'h8000; b16 = 16'h0002; end
         else begin
            sm16 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom);
            b16 = 16'($urandom);
         end
         sa = $signed(a16); sb = $signed(b16);
         ua = {16'd0, a16}; ub = {16'd0, b16};
         exp32 = sm16 ? 32'(sa * sb) : ua * ub;
         start16 = 1'b1;
         @(negedge clk);
         start16 = 1'b0;
         a16 = ~a16; b16 = ~b16; sm16 = ~sm16;
         n = 1;
         while (!done16 && n < 60) begin
            @(negedge clk);
            n++;
         end
         chk("w16_lat", 64'(n), 64'd20);
         chk("w16_prod", 64'(p16), 64'(exp32));
         @(negedge clk);
         chk("w16_hold", 64'(p16), 64'(exp32));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
